decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode stage for the MIPS32-style pipeline. It sits between fetch (IF) and execute (EX).
- Holds the architectural register file, which has a dedicated write-back port with write-through bypass.
- Splits the instruction into fields, sign-extends the immediate, and presents operands through an ID/EX pipeline register.
- Detects load-use hazards; supports downstream stall and flush.

Parameters:
- XLEN, 32, data/register width in bits.
- NREG, 32, register count; register index width RW = $clog2(NREG), at most 5.
- ZERO_R0, 1, when 1 register 0 reads as 0 and writes to it are discarded.
- OP_LOAD, 6'h23, opcode that marks a load, used for hazard detection.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF presents a valid instruction.
- if_npc  in  32  next-PC from IF.
- if_ir  in  32  instruction word from IF.
- if_ready  out  1  decode accepts the IF instruction this cycle.
- ex_stall  in  1  EX cannot accept; hold the ID/EX register.
- flush  in  1  kill the instruction in decode and the one being accepted.
- wb_en  in  1  register write enable.
- wb_rd  in  RW  write-back register index.
- wb_data  in  XLEN  write-back data.
- id_valid  out  1  ID/EX register holds a valid instruction.
- id_op  out  6  opcode, IR[31:26].
- id_rd  out  RW  IR[25:21] (truncated to RW).
- id_a  out  XLEN  reg[rs1], where rs1 = IR[20:16].
- id_b  out  XLEN  reg[rs2], where rs2 = IR[15:11].
- id_d  out  XLEN  reg[rd] (store data / third source).
- id_imm  out  XLEN  IR[15:0] sign-extended to XLEN.
- id_npc  out  32  registered if_npc.
- id_ir  out  32  registered if_ir.

Behaviour:
- Reset (rst_n low, async): all ID/EX outputs are 0, id_valid=0, and every register-file entry is 0. if_ready follows its combinational equation and equals 1 out of reset.
- Register file:
  - Synchronous write on the clk edge when wb_en=1, except when ZERO_R0=1 and wb_rd=0.
  - Reads are combinational from if_ir fields.
- Write-through bypass: if wb_en=1 and wb_rd equals a read index (and the index is not R0 with ZERO_R0=1), that operand takes wb_data in the same cycle.
- Load-use hazard, combinational: hazard=1 when all of the following hold:
  - id_valid=1 and id_op==OP_LOAD;
  - if_valid=1;
  - id_rd is nonzero (or ZERO_R0=0) and equals rs1, rs2 or rd of if_ir.
- if_ready = !ex_stall && !hazard.
- ID/EX register update per clk edge, in priority order:
  1. flush=1: id_valid<=0; other fields don't-care (implementation clears them to 0).
  2. ex_stall=1: all ID/EX fields hold.
  3. hazard=1: id_valid<=0 (one bubble); IF holds because if_ready=0.
  4. Otherwise: load all fields from if_ir/if_npc and the read operands; id_valid<=if_valid.
- Latency: one cycle from IF acceptance to the ID/EX outputs. A load followed by a dependent instruction costs exactly one bubble.
- Flush has priority over stall, and flush during a hazard clears the hazard bubble. Write-back continues during stall and flush.
- Immediate: id_imm = {{(XLEN-16){IR[15]}}, IR[15:0]}.
- Index fields wider than RW are truncated to their low RW bits.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_LOAD, OP_STORE, …);
  - field-position localparams (OP_HI=31, OP_LO=26, RD_HI=25, RS1_HI=20, RS2_HI=15);
  - function sext16 for the immediate.
- One natural sub-module: regfile_bypass, the NREG×XLEN array with three read ports, one write port, the bypass and R0 handling.
- decode_stage owns the hazard detection and the ID/EX register.

Test Plan:
- Reset then write: assert rst_n=0 mid-run; check id_valid=0 and all outputs 0 immediately. Then wb_en=1, wb_rd=3, wb_data=32'hDEAD_BEEF; on the next cycle, IR with rs1=3 gives id_a=32'hDEAD_BEEF.
- Bypass: wb_rd=5, wb_data=32'h1234 in the same cycle as an IR with rs2=5 → id_b=32'h1234 one cycle later. A write to R0 of 32'hFFFF, followed by a read of R0, gives 0.
- Immediate: IR[15:0]=16'h8001 → id_imm=32'hFFFF_8001; 16'h7FFF → 32'h0000_7FFF.
- Load-use: load to rd=7, followed by an instruction with rs1=7:
  - the cycle after the load enters ID: if_ready=0, then id_valid=0 for one cycle;
  - the dependent instruction appears one cycle later.
  - An independent follower (rs1=8) incurs no bubble.
- Stall/flush: ex_stall=1 for 3 cycles → id_* hold constant and if_ready=0. flush=1 together with ex_stall=1 → id_valid=0 on the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32-style decode constants: opcodes, instruction field positions
// and the immediate sign-extension helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file: one write port, three combinational read ports
// with write-through bypass and optional hard-wired zero register.
module regfile_bypass #(
    parameter int  XLEN    = 32,
    parameter int  NREG    = 32,
    parameter bit  ZERO_R0 = 1'b1,
    localparam int RW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic [RW-1:0]   rd,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [XLEN-1:0] d
);

    logic [XLEN-1:0] regs [NREG];
    logic [RW-1:0]   raddr [3];
    logic [XLEN-1:0] rdata [3];
    logic            wb_live;

    // A write to R0 is dropped both in the array and in the bypass path.
    assign wb_live = wb_en && !(ZERO_R0 && (wb_rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_rd == RW'(i)) begin
                    regs[i] <= wb_data;
                end
            end
        end
    end

    assign raddr[0] = rs1;
    assign raddr[1] = rs2;
    assign raddr[2] = rd;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rport
            always_comb begin
                rdata[gi] = '0;
                if (ZERO_R0 && (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end else if (wb_live && (wb_rd == raddr[gi])) begin
                    rdata[gi] = wb_data;
                end else if (int'(raddr[gi]) < NREG) begin
                    rdata[gi] = regs[raddr[gi]];
                end
            end
        end
    endgenerate

    assign a = rdata[0];
    assign b = rdata[1];
    assign d = rdata[2];

endmodule

// File: rtl/decode_stage.sv
// Registered ID stage: field split, operand read, load-use hazard detection
// and the ID/EX pipeline register with stall/flush handling.
module decode_stage #(
    parameter int         XLEN    = 32,
    parameter int         NREG    = 32,
    parameter bit         ZERO_R0 = 1'b1,
    parameter logic [5:0] OP_LOAD = 6'h23,
    localparam int        RW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_npc,
    input  logic [31:0]     if_ir,
    output logic            if_ready,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [5:0]      id_op,
    output logic [RW-1:0]   id_rd,
    output logic [XLEN-1:0] id_a,
    output logic [XLEN-1:0] id_b,
    output logic [XLEN-1:0] id_d,
    output logic [XLEN-1:0] id_imm,
    output logic [31:0]     id_npc,
    output logic [31:0]     id_ir
);

    import mips_pkg::OP_HI;
    import mips_pkg::OP_LO;
    import mips_pkg::RD_LO;
    import mips_pkg::RS1_LO;
    import mips_pkg::RS2_LO;
    import mips_pkg::IMM_HI;
    import mips_pkg::IMM_LO;
    import mips_pkg::sext16;

    logic [5:0]      f_op;
    logic [RW-1:0]   f_rd;
    logic [RW-1:0]   f_rs1;
    logic [RW-1:0]   f_rs2;
    logic [XLEN-1:0] f_imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] op_d;
    logic            hazard;

    assign f_op  = if_ir[OP_HI:OP_LO];
    assign f_rd  = if_ir[RD_LO +: RW];
    assign f_rs1 = if_ir[RS1_LO +: RW];
    assign f_rs2 = if_ir[RS2_LO +: RW];

    generate
        if (XLEN == 32) begin : g_imm32
            assign f_imm = sext16(if_ir[IMM_HI:IMM_LO]);
        end else begin : g_immn
            assign f_imm = {{(XLEN-16){if_ir[IMM_HI]}}, if_ir[IMM_HI:IMM_LO]};
        end
    endgenerate

    regfile_bypass #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .ZERO_R0 (ZERO_R0)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rs1     (f_rs1),
        .rs2     (f_rs2),
        .rd      (f_rd),
        .a       (op_a),
        .b       (op_b),
        .d       (op_d)
    );

    // The load's destination is only known to be stale if the follower reads it.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && (id_op == OP_LOAD) && if_valid &&
            ((id_rd != '0) || !ZERO_R0)) begin
            hazard = (id_rd == f_rs1) || (id_rd == f_rs2) || (id_rd == f_rd);
        end
    end

    assign if_ready = !ex_stall && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_op    <= '0;
            id_rd    <= '0;
            id_a     <= '0;
            id_b     <= '0;
            id_d     <= '0;
            id_imm   <= '0;
            id_npc   <= '0;
            id_ir    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_op    <= '0;
            id_rd    <= '0;
            id_a     <= '0;
            id_b     <= '0;
            id_d     <= '0;
            id_imm   <= '0;
            id_npc   <= '0;
            id_ir    <= '0;
        end else if (ex_stall) begin
            id_valid <= id_valid;
        end else if (hazard) begin
            // Bubble: only the valid bit drops, the load's fields are left as-is.
            id_valid <= 1'b0;
        end else begin
            id_valid <= if_valid;
            id_op    <= f_op;
            id_rd    <= f_rd;
            id_a     <= op_a;
            id_b     <= op_b;
            id_d     <= op_d;
            id_imm   <= f_imm;
            id_npc   <= if_npc;
            id_ir    <= if_ir;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: reset, register file/bypass,
// immediate, load-use bubble and stall/flush behaviour.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_npc;
    logic [31:0] if_ir;
    logic        if_ready;
    logic        ex_stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rd;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic [31:0] id_d;
    logic [31:0] id_imm;
    logic [31:0] id_npc;
    logic [31:0] id_ir;

    int checks_total = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_npc   (if_npc),
        .if_ir    (if_ir),
        .if_ready (if_ready),
        .ex_stall (ex_stall),
        .flush    (flush),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .id_valid (id_valid),
        .id_op    (id_op),
        .id_rd    (id_rd),
        .id_a     (id_a),
        .id_b     (id_b),
        .id_d     (id_d),
        .id_imm   (id_imm),
        .id_npc   (id_npc),
        .id_ir    (id_ir)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
            $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-16s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // rs2 is IR[15:11], i.e. the top five bits of imm16.
    function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm16);
        return {op, rd, rs1, imm16};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ir_x;
    logic [31:0] ir_dep;
    logic [31:0] ir_ind;

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_npc = '0; if_ir = '0;
        ex_stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        step(); step();
        rst_n = 1'b1;

        // Put something in ID, then reset mid-run.
        if_valid = 1'b1; if_npc = 32'h0000_0104; if_ir = mk_ir(6'h08, 5'd1, 5'd2, 16'h1111);
        step();
        check("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_ir", id_ir, 32'h0);
        check("rst_npc", id_npc, 32'h0);
        check("rst_imm", id_imm, 32'h0);
        check("rst_if_ready", {31'b0, if_ready}, 32'h1);
        step();
        rst_n = 1'b1;

        // Write r3, then read it via rs1.
        if_valid = 1'b0; if_ir = '0;
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        step();
        wb_en = 1'b0;
        if_valid = 1'b1; if_npc = 32'h0000_0200; if_ir = mk_ir(6'h00, 5'd1, 5'd3, 16'h0000);
        step();
        check("wr_valid", {31'b0, id_valid}, 32'h1);
        check("wr_id_a", id_a, 32'hDEAD_BEEF);
        check("wr_npc", id_npc, 32'h0000_0200);

        // Same-cycle bypass on rs2=5.
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        if_ir = mk_ir(6'h00, 5'd2, 5'd0, 16'h2800);
        step();
        check("byp_id_b", id_b, 32'h0000_1234);
        check("byp_id_a_r0", id_a, 32'h0);

        // Write to R0 is discarded, both bypassed and stored.
        wb_rd = 5'd0; wb_data = 32'h0000_FFFF;
        if_ir = mk_ir(6'h00, 5'd0, 5'd0, 16'h0000);
        step();
        check("r0_bypass", id_a, 32'h0);
        wb_en = 1'b0;
        if_ir = mk_ir(6'h00, 5'd5, 5'd0, 16'h0000);
        step();
        check("r0_read", id_a, 32'h0);
        check("r5_via_rd", id_d, 32'h0000_1234);

        // Immediate sign extension.
        if_ir = mk_ir(6'h08, 5'd0, 5'd0, 16'h8001);
        step();
        check("imm_neg", id_imm, 32'hFFFF_8001);
        if_ir = mk_ir(6'h08, 5'd0, 5'd0, 16'h7FFF);
        step();
        check("imm_pos", id_imm, 32'h0000_7FFF);

        // r8 gets a value for the independent-follower case.
        wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'hA5A5_0008;
        if_valid = 1'b0;
        step();
        wb_en = 1'b0;

        // Load to r7 followed by a dependent rs1=7.
        ir_dep = mk_ir(6'h00, 5'd9, 5'd7, 16'h0000);
        if_valid = 1'b1; if_npc = 32'h0000_0300; if_ir = mk_ir(6'h23, 5'd7, 5'd0, 16'h0004);
        step();
        check("ld_in_id", {26'b0, id_op}, 32'h23);
        if_npc = 32'h0000_0304; if_ir = ir_dep;
        #1;
        check("haz_if_ready", {31'b0, if_ready}, 32'h0);
        step();
        check("haz_bubble", {31'b0, id_valid}, 32'h0);
        check("haz_clear_rdy", {31'b0, if_ready}, 32'h1);
        step();
        check("dep_valid", {31'b0, id_valid}, 32'h1);
        check("dep_ir", id_ir, ir_dep);

        // Load to r7 followed by an independent rs1=8: no bubble.
        ir_ind = mk_ir(6'h00, 5'd9, 5'd8, 16'h0000);
        if_ir = mk_ir(6'h23, 5'd7, 5'd0, 16'h0004);
        step();
        if_ir = ir_ind;
        #1;
        check("ind_if_ready", {31'b0, if_ready}, 32'h1);
        step();
        check("ind_valid", {31'b0, id_valid}, 32'h1);
        check("ind_ir", id_ir, ir_ind);
        check("ind_id_a", id_a, 32'hA5A5_0008);

        // Stall for three cycles: ID/EX holds.
        ir_x = mk_ir(6'h00, 5'd4, 5'd3, 16'h0000);
        if_npc = 32'h0000_0400; if_ir = ir_x;
        step();
        ex_stall = 1'b1;
        if_npc = 32'h0000_0404; if_ir = mk_ir(6'h00, 5'd6, 5'd5, 16'h0000);
        #1;
        check("stall_if_ready", {31'b0, if_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_ir_%0d", i), id_ir, ir_x);
            check($sformatf("stall_a_%0d", i), id_a, 32'hDEAD_BEEF);
            check($sformatf("stall_v_%0d", i), {31'b0, id_valid}, 32'h1);
        end

        // Flush wins over stall.
        flush = 1'b1;
        step();
        check("flush_valid", {31'b0, id_valid}, 32'h0);
        check("flush_ir", id_ir, 32'h0);
        flush = 1'b0; ex_stall = 1'b0;

        // Flush during a hazard: bubble cleared, follower not accepted.
        if_ir = mk_ir(6'h23, 5'd7, 5'd0, 16'h0000);
        step();
        if_ir = ir_dep;
        flush = 1'b1;
        step();
        check("flush_haz_v", {31'b0, id_valid}, 32'h0);
        flush = 1'b0;
        #1;
        check("flush_haz_rdy", {31'b0, if_ready}, 32'h1);
        step();
        check("post_flush_ir", id_ir, ir_dep);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
